fifo_wr_packer: RTL and testbench

//  Write-domain front end placed directly upstream of the async FIFO write port.
//  - Accepts a narrow valid/ready stream and packs RATIO beats into one DATASIZE word.
//  - Holds completed words in a 2-entry skid buffer and drives the FIFO write port, respecting FIFO full.
//  - Performs its own 2-FF write-reset synchronisation.

---
 rtl/fifo_wr_packer_pkg.sv | 18 +
 rtl/fifo_wr_packer_rst_sync.sv | 24 ++
 rtl/fifo_wr_packer.sv | 131 +++++++++++++
 tb/tb_fifo_wr_packer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_packer_pkg.sv
// Shared defaults and types for the FIFO write-side packer.
// The FIFO and its bench use the same word-size defaults.
package fifo_wr_packer_pkg;

  localparam int DEF_DATASIZE = 8;
  localparam int DEF_IN_WIDTH = 4;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_ADDRSIZE = 4;
  localparam int DEF_MEM_DEPTH = 1 << DEF_ADDRSIZE;

  typedef enum logic [1:0] {
    SKID_IDLE = 2'b00,
    SKID_POP  = 2'b01,
    SKID_PUSH = 2'b10,
    SKID_BOTH = 2'b11
  } skid_op_e;

endpackage

// File: rtl/fifo_wr_packer_rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, deasserts on the
// second rising clock edge after the raw reset is released.
module rst_sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_rst_n
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= 1'b1;
      sync_q <= meta_q;
    end
  end

  assign o_rst_n = sync_q;

endmodule

// File: rtl/fifo_wr_packer.sv
// Packs narrow input beats into FIFO words, buffers up to two finished words
// and drives the async FIFO write port while honouring its full flag.
module fifo_wr_packer
  import fifo_wr_packer_pkg::*;
#(
  parameter int DATASIZE = DEF_DATASIZE,
  parameter int IN_WIDTH = DEF_IN_WIDTH,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                i_wr_clk,
  input  logic                i_wr_rst_n,
  input  logic                i_s_valid,
  output logic                o_s_ready,
  input  logic [IN_WIDTH-1:0] i_s_data,
  input  logic                i_s_last,
  input  logic                i_full,
  output logic                o_wr_en,
  output logic [DATASIZE-1:0] o_wr_data,
  output logic [CNT_W-1:0]    o_wr_count,
  output logic                o_busy
);

  localparam int RATIO  = DATASIZE / IN_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  if (((DATASIZE % IN_WIDTH) != 0) || (RATIO < 2)) begin : gBadParams
    $error("fifo_wr_packer: DATASIZE must be a multiple (>=2) of IN_WIDTH");
  end

  logic                rstSyncN;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [DATASIZE-1:0] acc_q, acc_d;
  logic [DATASIZE-1:0] beatWord;
  logic [DATASIZE-1:0] head_q, head_d;
  logic [DATASIZE-1:0] tail_q, tail_d;
  logic [1:0]          skidCnt_q, skidCnt_d;
  logic [CNT_W-1:0]    wrCount_q, wrCount_d;
  logic                accept;
  logic                complete;
  logic                push;
  logic                pop;
  skid_op_e            skidOp;

  rst_sync_2ff uRstSync (
    .i_clk   (i_wr_clk),
    .i_rst_n (i_wr_rst_n),
    .o_rst_n (rstSyncN)
  );

  // Ready looks only at buffer occupancy so it never combinationally follows i_full.
  assign o_s_ready  = rstSyncN & (skidCnt_q != 2'd2);
  assign accept     = i_s_valid & o_s_ready;
  assign complete   = i_s_last | (lane_q == LANE_W'(RATIO - 1));
  assign push       = accept & complete;
  assign o_wr_en    = rstSyncN & (skidCnt_q != 2'd0) & ~i_full;
  assign pop        = o_wr_en;
  assign o_wr_data  = head_q;
  assign o_wr_count = wrCount_q;
  assign o_busy     = (lane_q != '0) | (skidCnt_q != 2'd0);
  assign skidOp     = skid_op_e'({push, pop});

  always_comb begin
    beatWord = acc_q;
    beatWord[lane_q*IN_WIDTH +: IN_WIDTH] = i_s_data;
    lane_d = lane_q;
    acc_d  = acc_q;
    if (accept) begin
      if (complete) begin
        lane_d = '0;
        acc_d  = '0;
      end else begin
        lane_d = lane_q + 1'b1;
        acc_d  = beatWord;
      end
    end
  end

  // With a simultaneous push and pop the tail slides into the head first, keeping order.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    skidCnt_d = skidCnt_q;
    wrCount_d = wrCount_q;
    if (pop) begin
      wrCount_d = wrCount_q + 1'b1;
    end
    case (skidOp)
      SKID_PUSH: begin
        if (skidCnt_q == 2'd0) begin
          head_d = beatWord;
        end else begin
          tail_d = beatWord;
        end
        skidCnt_d = skidCnt_q + 2'd1;
      end
      SKID_POP: begin
        head_d    = tail_q;
        skidCnt_d = skidCnt_q - 2'd1;
      end
      SKID_BOTH: begin
        if (skidCnt_q == 2'd1) begin
          head_d = beatWord;
        end else begin
          head_d = tail_q;
          tail_d = beatWord;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_wr_clk or negedge rstSyncN) begin
    if (!rstSyncN) begin
      lane_q    <= '0;
      acc_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      skidCnt_q <= 2'd0;
      wrCount_q <= '0;
    end else begin
      lane_q    <= lane_d;
      acc_q     <= acc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      skidCnt_q <= skidCnt_d;
      wrCount_q <= wrCount_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Scoreboard bench for fifo_wr_packer: expected words are queued as beats are
// sent and a negedge monitor checks every FIFO write against the queue.
module tb_fifo_wr_packer;

  localparam int DS = 8;
  localparam int IW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          sValid = 1'b0;
  logic [IW-1:0] sData = '0;
  logic          sLast = 1'b0;
  logic          full = 1'b0;
  logic          sReady;
  logic          wrEn;
  logic [DS-1:0] wrData;
  logic [CW-1:0] wrCount;
  logic          busy;

  int            total = 0;
  int            bad = 0;
  logic [DS-1:0] expQ[$];
  int            expCount = 0;
  bit            useModel = 1'b0;
  bit            randFull = 1'b0;
  int            mLane = 0;
  logic [DS-1:0] mAcc = '0;

  fifo_wr_packer #(.DATASIZE(DS), .IN_WIDTH(IW), .CNT_W(CW)) dut (
    .i_wr_clk   (clk),
    .i_wr_rst_n (rstN),
    .i_s_valid  (sValid),
    .o_s_ready  (sReady),
    .i_s_data   (sData),
    .i_s_last   (sLast),
    .i_full     (full),
    .o_wr_en    (wrEn),
    .o_wr_data  (wrData),
    .o_wr_count (wrCount),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  // Drives one beat (called at posedge+1) and holds it until accepted.
  task automatic applyStimulus(input logic [IW-1:0] d, input logic l);
    bit acc = 1'b0;
    sValid = 1'b1;
    sData  = d;
    sLast  = l;
    for (int i = 0; i < 300 && !acc; i++) begin
      acc = sReady;
      @(posedge clk);
      #1;
    end
    if (!acc) checkOutput("beat_accept_timeout", 32'd0, 32'd1);
    sValid = 1'b0;
    if (acc && useModel) begin
      mAcc[mLane*IW +: IW] = d;
      if (l || mLane == (DS / IW) - 1) begin
        expQ.push_back(mAcc);
        mAcc  = '0;
        mLane = 0;
      end else begin
        mLane++;
      end
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every FIFO write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wrEn) begin
      checkOutput("wr_en_while_full", 32'(full), 32'd0);
      checkOutput("write_expected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        checkOutput("wr_data", 32'(wrData), 32'(expQ.pop_front()));
        checkOutput("wr_count", 32'(wrCount), 32'(expCount));
        expCount = (expCount + 1) % (1 << CW);
      end
    end
  end

  always @(posedge clk) begin
    if (randFull) begin
      #1;
      full = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    bit gotReady;

    // Reset behaviour
    #12;
    checkOutput("rst_ready", 32'(sReady), 32'd0);
    checkOutput("rst_wr_en", 32'(wrEn), 32'd0);
    checkOutput("rst_wr_data", 32'(wrData), 32'd0);
    checkOutput("rst_count", 32'(wrCount), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #3 rstN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("ready_after_1_edge", 32'(sReady), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("ready_after_2_edges", 32'(sReady), 32'd1);
    @(posedge clk);
    #1;

    // Two full words
    expQ.push_back(8'h21);
    expQ.push_back(8'h43);
    applyStimulus(4'h1, 1'b0);
    applyStimulus(4'h2, 1'b0);
    applyStimulus(4'h3, 1'b0);
    applyStimulus(4'h4, 1'b0);
    waitCycles(3);
    checkOutput("t2_count", 32'(wrCount), 32'd2);
    checkOutput("t2_busy", 32'(busy), 32'd0);

    // Single-beat frame flushed zero-padded, one cycle latency
    expQ.push_back(8'h05);
    applyStimulus(4'h5, 1'b1);
    checkOutput("t3_latency_en", 32'(wrEn), 32'd1);
    checkOutput("t3_latency_data", 32'(wrData), 32'h05);
    waitCycles(2);
    checkOutput("t3_busy", 32'(busy), 32'd0);
    checkOutput("t3_count", 32'(wrCount), 32'd3);

    // Back-pressure from a full FIFO
    full = 1'b1;
    expQ.push_back(8'h21);
    expQ.push_back(8'h43);
    expQ.push_back(8'h65);
    fork
      begin
        for (int b = 1; b <= 6; b++) applyStimulus(IW'(b), 1'b0);
      end
    join_none
    waitCycles(10);
    checkOutput("t4_ready_low", 32'(sReady), 32'd0);
    checkOutput("t4_wr_en_low", 32'(wrEn), 32'd0);
    checkOutput("t4_busy", 32'(busy), 32'd1);
    full = 1'b0;
    #1;
    checkOutput("t4_first_en", 32'(wrEn), 32'd1);
    checkOutput("t4_first_data", 32'(wrData), 32'h21);
    waitCycles(1);
    checkOutput("t4_second_en", 32'(wrEn), 32'd1);
    checkOutput("t4_second_data", 32'(wrData), 32'h43);
    wait fork;
    waitCycles(3);
    checkOutput("t4_count", 32'(wrCount), 32'd6);

    // Reset in the middle of a word
    applyStimulus(4'h7, 1'b0);
    #2 rstN = 1'b0;
    #1;
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_count", 32'(wrCount), 32'd0);
    checkOutput("t5_rst_ready", 32'(sReady), 32'd0);
    expCount = 0;
    @(posedge clk);
    #2 rstN = 1'b1;
    gotReady = 1'b0;
    for (int i = 0; i < 10 && !gotReady; i++) begin
      @(posedge clk);
      #1;
      gotReady = sReady;
    end
    checkOutput("t5_ready_return", 32'(gotReady), 32'd1);
    expQ.push_back(8'h98);
    applyStimulus(4'h8, 1'b0);
    applyStimulus(4'h9, 1'b0);
    waitCycles(3);
    checkOutput("t5_count", 32'(wrCount), 32'd1);

    // Random traffic with random FIFO full and counter wrap
    useModel = 1'b1;
    randFull = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) waitCycles($urandom_range(1, 3));
      applyStimulus(IW'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0));
    end
    applyStimulus(4'hA, 1'b1);
    randFull = 1'b0;
    @(posedge clk);
    #2 full = 1'b0;
    for (int i = 0; i < 50 && expQ.size() != 0; i++) waitCycles(1);
    waitCycles(2);
    checkOutput("t6_drained", 32'(expQ.size()), 32'd0);
    checkOutput("t6_final_count", 32'(wrCount), 32'(expCount));
    checkOutput("t6_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
